// File: rtl/sram_ctrl_pkg.sv
// Shared types and geometry for the 16-bit asynchronous SRAM controller.
// Halfword selection helper used when splitting a write word onto the SRAM bus.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SRAM_DW = 16;
    localparam int SRAM_AW = 18;
    localparam int LINE_HW = 4;
    localparam int WORD_HW = 2;

    function automatic logic [SRAM_DW-1:0] word_half(input logic [31:0] word, input logic sel);
        logic [SRAM_DW-1:0] half;
        if (sel) begin
            half = word[31:16];
        end else begin
            half = word[15:0];
        end
        return half;
    endfunction

endpackage

// File: rtl/sram_slot_timer.sv
// Slot/halfword counter pair: slot counts wait states within a halfword access,
// idx advances on each slot wrap and stops at the last halfword of the transfer.
module sram_slot_timer #(
    parameter int WAIT_CYCLES = 2,
    parameter int HW_COUNT    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    output logic [1:0] idx,
    output logic       slot_last,
    output logic       hw_last
);

    localparam logic [3:0] SLOT_MAX = 4'(WAIT_CYCLES - 1);
    localparam logic [1:0] IDX_MAX  = 2'(HW_COUNT - 1);

    logic [3:0] slot;

    assign slot_last = (slot == SLOT_MAX);
    assign hw_last   = (idx == IDX_MAX);

    // Slot and halfword counters; idx saturates at the final halfword.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= 4'd0;
            idx  <= 2'd0;
        end else if (clear) begin
            slot <= 4'd0;
            idx  <= 2'd0;
        end else if (enable) begin
            if (slot_last) begin
                slot <= 4'd0;
                if (!hw_last) begin
                    idx <= idx + 2'd1;
                end
            end else begin
                slot <= slot + 4'd1;
            end
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// Cache-side sequencer for the board SRAM: 64-bit line reads as four halfword
// accesses, 32-bit word writes as two, each halfword stretched over WAIT_CYCLES clocks.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [31:0]          address,
    input  logic [31:0]          wdata,
    output logic [63:0]          rdata,
    output logic                 ready,
    inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_OE_N
);

    state_t state;
    state_t next_state;

    logic [31:0]        off_full;
    logic [18:2]        off_r;
    logic [31:0]        wdata_r;
    logic               accept;
    logic [1:0]         rd_idx;
    logic [1:0]         wr_idx;
    logic               rd_slot_last;
    logic               rd_hw_last;
    logic               wr_slot_last;
    logic               wr_hw_last;
    logic               dq_drive;
    logic [SRAM_DW-1:0] dq_out;
    logic               unused_bits;

    // Bits above 18 fall outside the 18-bit halfword space and are discarded.
    assign off_full    = address - BASE_ADDR;
    assign unused_bits = ^{off_full[31:19], off_full[1:0], wr_idx[1]};
    assign accept      = (state == IDLE) && (wr_en || rd_en);

    sram_slot_timer #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .HW_COUNT    (LINE_HW)
    ) u_rd_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == IDLE),
        .enable    (state == READ),
        .idx       (rd_idx),
        .slot_last (rd_slot_last),
        .hw_last   (rd_hw_last)
    );

    sram_slot_timer #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .HW_COUNT    (WORD_HW)
    ) u_wr_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == IDLE),
        .enable    (state == WRITE),
        .idx       (wr_idx),
        .slot_last (wr_slot_last),
        .hw_last   (wr_hw_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a write request beats a simultaneous read.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    next_state = WRITE;
                end else if (rd_en) begin
                    next_state = READ;
                end else begin
                    next_state = IDLE;
                end
            end
            READ: begin
                if (rd_slot_last && rd_hw_last) begin
                    next_state = DONE;
                end else begin
                    next_state = READ;
                end
            end
            WRITE: begin
                if (wr_slot_last && wr_hw_last) begin
                    next_state = DONE;
                end else begin
                    next_state = WRITE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch: offset and write word are frozen for the whole transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_r   <= 17'd0;
            wdata_r <= 32'd0;
        end else if (accept) begin
            off_r   <= off_full[18:2];
            wdata_r <= wdata;
        end
    end

    // Line assembly: each halfword is sampled at the end of its last wait state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 64'd0;
        end else if ((state == READ) && rd_slot_last) begin
            rdata[{rd_idx, 4'd0} +: SRAM_DW] <= SRAM_DQ;
        end
    end

    // Pin decode; WE_N releases one slot cycle early so address/data outlast it.
    always_comb begin
        SRAM_ADDR = {SRAM_AW{1'b0}};
        SRAM_WE_N = 1'b1;
        dq_drive  = 1'b0;
        dq_out    = {SRAM_DW{1'b0}};
        ready     = 1'b0;
        case (state)
            READ: begin
                SRAM_ADDR = {off_r[18:3], rd_idx};
            end
            WRITE: begin
                SRAM_ADDR = {off_r[18:2], wr_idx[0]};
                SRAM_WE_N = wr_slot_last;
                dq_drive  = 1'b1;
                dq_out    = word_half(wdata_r, wr_idx[0]);
            end
            DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign SRAM_DQ   = dq_drive ? dq_out : 16'hzzzz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a transaction-level model predicts ready timing, pin
// sequence and line contents every cycle (W=2); a second instance covers W=5.
module tb_sram_ctrl;

    localparam int          W_A  = 2;
    localparam int          W_B  = 5;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_en_a, wr_en_a, rd_en_b, wr_en_b;
    logic [31:0] address_a, wdata_a, address_b, wdata_b;
    logic [63:0] rdata_a, rdata_b;
    logic        ready_a, ready_b;
    wire  [15:0] dq_a, dq_b;
    logic [17:0] addr_a, addr_b;
    logic        we_n_a, ub_a, lb_a, ce_a, oe_a;
    logic        we_n_b, ub_b, lb_b, ce_b, oe_b;
    logic        rd_phase_a, rd_phase_b;

    logic [15:0] mem_a [0:262143];
    logic [15:0] ref_a [0:262143];
    logic [15:0] mem_b [0:262143];

    int n_checks = 0;
    int n_errors = 0;

    sram_ctrl #(.WAIT_CYCLES(W_A), .BASE_ADDR(BASE)) dut_a (
        .clk(clk), .rst(rst), .rd_en(rd_en_a), .wr_en(wr_en_a), .address(address_a),
        .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .SRAM_DQ(dq_a), .SRAM_ADDR(addr_a),
        .SRAM_WE_N(we_n_a), .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a)
    );

    sram_ctrl #(.WAIT_CYCLES(W_B), .BASE_ADDR(BASE)) dut_b (
        .clk(clk), .rst(rst), .rd_en(rd_en_b), .wr_en(wr_en_b), .address(address_b),
        .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .SRAM_DQ(dq_b), .SRAM_ADDR(addr_b),
        .SRAM_WE_N(we_n_b), .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b), .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b)
    );

    // SRAM parts: output enabled only while the bench runs a read, write while WE_N low.
    assign dq_a = (rd_phase_a && we_n_a) ? mem_a[addr_a] : 16'hzzzz;
    assign dq_b = (rd_phase_b && we_n_b) ? mem_b[addr_b] : 16'hzzzz;
    always @(posedge clk) if (!we_n_a) mem_a[addr_a] <= dq_a;
    always @(posedge clk) if (!we_n_b) mem_b[addr_b] <= dq_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] line_base(input logic [31:0] off);
        return 18'((off >> 1) & 32'h0003FFFC);
    endfunction

    function automatic logic [17:0] word_base(input logic [31:0] off);
        return 18'((off >> 1) & 32'h0003FFFE);
    endfunction

    function automatic logic [63:0] line_of(input logic [31:0] off);
        logic [63:0] line;
        logic [17:0] a;
        for (int k = 0; k < 4; k++) begin
            a = line_base(off) + 18'(k);
            line[16*k +: 16] = ref_a[a];
        end
        return line;
    endfunction

    // Transaction model for instance A: cycle numbers count clock edges.
    int          cyc = 0;
    int          m_acc = -100;
    int          m_done = -100;
    bit          m_rd = 1'b0;
    logic [31:0] m_off = 32'd0;
    logic [31:0] m_wd = 32'd0;
    logic [63:0] exp_rdata = 64'd0;

    always @(posedge clk or posedge rst) begin : model
        int c;
        logic [17:0] hb;
        hb = word_base(m_off);
        if (rst) begin
            if (!m_rd && cyc >= m_acc && cyc < m_done && m_acc + W_A <= cyc)
                ref_a[hb] <= m_wd[15:0];
            m_acc     <= -100;
            m_done    <= -100;
            exp_rdata <= 64'd0;
        end else begin
            c = cyc + 1;
            cyc <= c;
            if (c == m_done) begin
                if (m_rd) begin
                    exp_rdata <= line_of(m_off);
                end else begin
                    ref_a[hb]         <= m_wd[15:0];
                    ref_a[hb + 18'd1] <= m_wd[31:16];
                end
            end
            if (c >= m_done + 2 && (wr_en_a || rd_en_a)) begin
                m_rd   <= !wr_en_a;
                m_off  <= address_a - BASE;
                m_wd   <= wdata_a;
                m_acc  <= c;
                m_done <= c + (wr_en_a ? 2 * W_A : 4 * W_A);
            end
        end
    end

    // Per-cycle comparison of instance A against the model.
    always @(negedge clk) begin : compare
        int k;
        int ph;
        logic [17:0] ea;
        if (rst) begin
            check("rst_ready", 64'(ready_a), 64'd0);
            check("rst_rdata", rdata_a, 64'd0);
            check("rst_we_n", 64'(we_n_a), 64'd1);
            check("rst_addr", 64'(addr_a), 64'd0);
            check("tie_offs", 64'({ub_a, lb_a, ce_a, oe_a}), 64'd0);
        end else begin
            check("ready", 64'(ready_a), 64'(cyc == m_done));
            if (cyc >= m_acc && cyc < m_done) begin
                k  = (cyc - m_acc) / W_A;
                ph = (cyc - m_acc) % W_A;
                ea = (m_rd ? line_base(m_off) : word_base(m_off)) + 18'(k);
                check("sram_addr", 64'(addr_a), 64'(ea));
                check("we_n", 64'(we_n_a), 64'(m_rd || ph == W_A - 1));
                if (!m_rd) check("dq", 64'(dq_a), 64'(k == 0 ? m_wd[15:0] : m_wd[31:16]));
                else if (k == 0) check("rdata_hold", rdata_a, exp_rdata);
            end else begin
                check("idle_addr", 64'(addr_a), 64'd0);
                check("idle_we_n", 64'(we_n_a), 64'd1);
                check("rdata", rdata_a, exp_rdata);
            end
        end
    end

    task automatic preload(input logic [17:0] a, input logic [15:0] v);
        mem_a[a] <= v;
        ref_a[a] <= v;
    endtask

    // Requester for A: holds the request until n_ready pulses; lat = cycles to first ready.
    task automatic req_a(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input int n_ready, input string name, output int lat);
        int got;
        got = 0;
        lat = -1;
        @(negedge clk);
        address_a  = a;
        wdata_a    = d;
        wr_en_a    = w;
        rd_en_a    = r;
        rd_phase_a = r && !w;
        for (int t = 0; t < 100 && got < n_ready; t++) begin
            @(negedge clk);
            if (ready_a) begin
                if (got == 0) lat = t;
                got++;
                wr_en_a = 1'b0;
                if (got >= n_ready) begin
                    rd_en_a    = 1'b0;
                    rd_phase_a = 1'b0;
                end else begin
                    rd_phase_a = rd_en_a;
                end
            end
        end
        check({name, "_ready_count"}, 64'(got), 64'(n_ready));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        rst = 1'b1;
        {rd_en_a, wr_en_a, rd_en_b, wr_en_b} = 4'b0000;
        address_a = 32'd0; wdata_a = 32'd0; address_b = 32'd0; wdata_b = 32'd0;
        rd_phase_a = 1'b0; rd_phase_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        check("post_rst_ready", 64'(ready_a), 64'd0);
        check("post_rst_rdata", rdata_a, 64'd0);

        // 1: word write lands in halfwords 4 and 5
        req_a(1'b1, 1'b0, BASE + 32'd8, 32'hDEADBEEF, 1, "t1", lat);
        check("t1_latency", 64'(lat), 64'd4);
        check("t1_mem4", 64'(mem_a[4]), 64'h0000_0000_0000_BEEF);
        check("t1_mem5", 64'(mem_a[5]), 64'h0000_0000_0000_DEAD);

        // 2: line read of fresh data
        preload(18'd4, 16'h1111); preload(18'd5, 16'h2222);
        preload(18'd6, 16'h3333); preload(18'd7, 16'h4444);
        req_a(1'b0, 1'b1, BASE + 32'd8, 32'd0, 1, "t2", lat);
        check("t2_latency", 64'(lat), 64'd8);
        check("t2_rdata", rdata_a, 64'h4444_3333_2222_1111);

        // 3: simultaneous requests, write first then read back
        preload(18'd14, 16'h5555); preload(18'd15, 16'h6666);
        req_a(1'b1, 1'b1, BASE + 32'd24, 32'hCAFEF00D, 2, "t3", lat);
        check("t3_latency", 64'(lat), 64'd4);
        check("t3_rdata", rdata_a, 64'h6666_5555_CAFE_F00D);

        // 4: reset during write halfword 1, slot 0
        preload(18'd17, 16'h0BAD); preload(18'd18, 16'h0C00); preload(18'd19, 16'h0C01);
        @(negedge clk);
        address_a = BASE + 32'd32; wdata_a = 32'h12345678; wr_en_a = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("t4_we_low", 64'(we_n_a), 64'd0);
        rst = 1'b1;
        #1 check("t4_we_async", 64'(we_n_a), 64'd1);
        check("t4_no_ready", 64'(ready_a), 64'd0);
        check("t4_rdata_clr", rdata_a, 64'd0);
        wr_en_a = 1'b0;
        @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        check("t4_mem16", 64'(mem_a[16]), 64'h0000_0000_0000_5678);
        check("t4_mem17", 64'(mem_a[17]), 64'h0000_0000_0000_0BAD);
        req_a(1'b0, 1'b1, BASE + 32'd32, 32'd0, 1, "t4r", lat);
        check("t4_rdata", rdata_a, 64'h0C01_0C00_0BAD_5678);

        // 5: W=5 instance, request dropped early
        mem_b[8] <= 16'hB000; mem_b[9] <= 16'hB001; mem_b[10] <= 16'hB002; mem_b[11] <= 16'hB003;
        @(negedge clk);
        address_b = BASE + 32'd16; rd_en_b = 1'b1; rd_phase_b = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("b_addr", 64'(addr_b), 64'(8 + c / W_B));
            check("b_ready_low", 64'(ready_b), 64'd0);
            if (c == 3) rd_en_b = 1'b0;
        end
        @(negedge clk);
        check("b_ready", 64'(ready_b), 64'd1);
        check("b_rdata", rdata_b, 64'hB003_B002_B001_B000);
        rd_phase_b = 1'b0;
        @(negedge clk);
        check("b_ready_once", 64'(ready_b), 64'd0);

        // 6: high address bits discarded; top of the SRAM
        req_a(1'b0, 1'b1, 32'hFFF80408, 32'd0, 1, "t6a", lat);
        check("t6a_rdata", rdata_a, 64'h4444_3333_2222_1111);
        preload(18'h3FFFC, 16'hA000); preload(18'h3FFFD, 16'hA001);
        preload(18'h3FFFE, 16'hA002); preload(18'h3FFFF, 16'hA003);
        req_a(1'b0, 1'b1, BASE + 32'h0007FFF8, 32'd0, 1, "t6b", lat);
        check("t6b_rdata", rdata_a, 64'hA003_A002_A001_A000);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
